// File: rtl/noc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | noc_pkg : shared flit layout, type codes and mesh defaults       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package noc_pkg;

    localparam int c_NUM_NODES_DEF = 9;
    localparam int c_ADDR_BITS_DEF = 4;

    localparam int         c_TYPE_HI = 31;
    localparam int         c_TYPE_LO = 30;
    localparam logic [1:0] c_FT_HEAD = 2'b01;
    localparam logic [1:0] c_FT_BODY = 2'b00;
    localparam logic [1:0] c_FT_TAIL = 2'b10;

    localparam int c_DEST_LO     = 26;
    localparam int c_DEST_W      = 4;
    localparam int c_SRC_LO      = 22;
    localparam int c_SRC_W       = 4;
    localparam int c_PKT_ID_LO   = 6;
    localparam int c_PKT_ID_W    = 16;
    localparam int c_BODY_IDX_LO = 16;
    localparam int c_BODY_IDX_W  = 4;
    localparam int c_TS_LO       = 0;
    localparam int c_TS_W        = 16;

    function automatic logic [31:0] mk_head(input logic [c_DEST_W-1:0]   dest,
                                            input logic [c_SRC_W-1:0]    src,
                                            input logic [c_PKT_ID_W-1:0] pkt_id);
        logic [31:0] f;
        f = '0;
        f[c_TYPE_HI:c_TYPE_LO]         = c_FT_HEAD;
        f[c_DEST_LO +: c_DEST_W]       = dest;
        f[c_SRC_LO +: c_SRC_W]         = src;
        f[c_PKT_ID_LO +: c_PKT_ID_W]   = pkt_id;
        return f;
    endfunction

    function automatic logic [31:0] mk_body(input logic [c_BODY_IDX_W-1:0] idx,
                                            input logic [c_TS_W-1:0]       ts);
        logic [31:0] f;
        f = '0;
        f[c_TYPE_HI:c_TYPE_LO]           = c_FT_BODY;
        f[c_BODY_IDX_LO +: c_BODY_IDX_W] = idx;
        f[c_TS_LO +: c_TS_W]             = ts;
        return f;
    endfunction

    function automatic logic [31:0] mk_tail(input logic [c_PKT_ID_W-1:0] pkt_id);
        logic [31:0] f;
        f = '0;
        f[c_TYPE_HI:c_TYPE_LO]       = c_FT_TAIL;
        f[c_PKT_ID_LO +: c_PKT_ID_W] = pkt_id;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sync_fifo : width/depth parameterised FIFO, no push-pop bypass   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       front_data,
    output logic [WIDTH-1:0]       next_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_push;
    logic             w_pop;
    logic [c_AW-1:0]  w_next_idx;

    // Full is judged on the current occupancy, so a pop never frees room for a same-edge push.
    assign w_push     = push & ~full;
    assign w_pop      = pop & ~empty;
    assign count      = r_wr_ptr - r_rd_ptr;
    assign full       = (count == (c_AW+1)'(DEPTH));
    assign empty      = (r_wr_ptr == r_rd_ptr);
    assign w_next_idx = r_rd_ptr[c_AW-1:0] + c_AW'(1);
    assign front_data = r_mem[r_rd_ptr[c_AW-1:0]];
    assign next_data  = r_mem[w_next_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/traffic_source.sv
`default_nettype none
// +------------------------------------------------------------------+
// | traffic_source : Bernoulli packet injector feeding a router port |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
// The random word input is named rand_val because rand is a reserved word.
module traffic_source
    import noc_pkg::*;
#(
    parameter int NODE_ID       = 0,
    parameter int NUM_NODES     = c_NUM_NODES_DEF,
    parameter int ADDR_BITS     = c_ADDR_BITS_DEF,
    parameter int RATE_THRESH   = 26,
    parameter int FLITS_PER_PKT = 4,
    parameter int QUEUE_DEPTH   = 4,
    parameter int FLIT_BITS     = 32,
    parameter int CNT_BITS      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 send,
    input  logic [31:0]          rand_val,
    output logic [FLIT_BITS-1:0] flit_out,
    output logic                 flit_valid,
    input  logic                 flit_ready,
    output logic [CNT_BITS-1:0]  pkts_injected,
    output logic [CNT_BITS-1:0]  pkts_dropped,
    output logic                 busy
);

    localparam int c_ENTRY_W = ADDR_BITS + 2 * CNT_BITS;
    localparam int c_QCNT_W  = $clog2(QUEUE_DEPTH) + 1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HEAD = 2'd1;
    localparam logic [1:0] c_ST_BODY = 2'd2;
    localparam logic [1:0] c_ST_TAIL = 2'd3;

    logic [1:0]           r_state;
    logic [CNT_BITS-1:0]  r_ts;
    logic [CNT_BITS-1:0]  r_next_id;
    logic [CNT_BITS-1:0]  r_injected;
    logic [CNT_BITS-1:0]  r_dropped;
    logic [ADDR_BITS-1:0] r_dest;
    logic [CNT_BITS-1:0]  r_pkt_id;
    logic [CNT_BITS-1:0]  r_pkt_ts;
    logic [3:0]           r_idx;
    logic                 r_valid;
    logic [FLIT_BITS-1:0] r_flit;

    logic [31:0]          w_dest_mod;
    logic [ADDR_BITS-1:0] w_dest;
    logic                 w_req;
    logic                 w_xfer;
    logic                 w_pop;
    logic [c_ENTRY_W-1:0] w_entry;
    logic [c_ENTRY_W-1:0] w_front;
    logic [c_ENTRY_W-1:0] w_next;
    logic                 w_full;
    logic                 w_empty;
    logic [c_QCNT_W-1:0]  w_count;
    logic                 w_unused_rand;

    assign w_unused_rand = ^rand_val[31:16];

    assign w_req      = send & ({24'd0, rand_val[7:0]} < 32'(RATE_THRESH));
    assign w_dest_mod = {24'd0, rand_val[15:8]} % 32'(NUM_NODES);
    // A packet is never addressed to its own source; bump to the next node.
    assign w_dest     = (w_dest_mod == 32'(NODE_ID)) ? ADDR_BITS'((NODE_ID + 1) % NUM_NODES)
                                                     : ADDR_BITS'(w_dest_mod);
    assign w_entry    = {w_dest, r_next_id, r_ts};
    assign w_xfer     = r_valid & flit_ready;
    assign w_pop      = w_xfer & (r_state == c_ST_TAIL);

    sync_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_req_q (
        .clk        (clk),
        .reset      (reset),
        .push       (w_req),
        .push_data  (w_entry),
        .pop        (w_pop),
        .front_data (w_front),
        .next_data  (w_next),
        .full       (w_full),
        .empty      (w_empty),
        .count      (w_count)
    );

    assign flit_out      = r_flit;
    assign flit_valid    = r_valid;
    assign pkts_injected = r_injected;
    assign pkts_dropped  = r_dropped;
    assign busy          = ~w_empty | (r_state != c_ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ts       <= '0;
            r_next_id  <= '0;
            r_injected <= '0;
            r_dropped  <= '0;
        end else begin
            r_ts <= r_ts + CNT_BITS'(1);
            if (w_req && !w_full) r_next_id  <= r_next_id + CNT_BITS'(1);
            if (w_req && w_full)  r_dropped  <= r_dropped + CNT_BITS'(1);
            if (w_pop)            r_injected <= r_injected + CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_dest   <= '0;
            r_pkt_id <= '0;
            r_pkt_ts <= '0;
            r_idx    <= '0;
            r_valid  <= 1'b0;
            r_flit   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!w_empty) begin
                        r_state  <= c_ST_HEAD;
                        r_dest   <= w_front[c_ENTRY_W-1 -: ADDR_BITS];
                        r_pkt_id <= w_front[2*CNT_BITS-1:CNT_BITS];
                        r_pkt_ts <= w_front[CNT_BITS-1:0];
                    end
                end
                c_ST_HEAD: begin
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                        r_flit  <= FLIT_BITS'(mk_head(c_DEST_W'(r_dest), c_SRC_W'(NODE_ID),
                                                      c_PKT_ID_W'(r_pkt_id)));
                    end else if (w_xfer) begin
                        r_idx <= 4'd1;
                        if (FLITS_PER_PKT == 2) begin
                            r_state <= c_ST_TAIL;
                            r_flit  <= FLIT_BITS'(mk_tail(c_PKT_ID_W'(r_pkt_id)));
                        end else begin
                            r_state <= c_ST_BODY;
                            r_flit  <= FLIT_BITS'(mk_body(4'd1, c_TS_W'(r_pkt_ts)));
                        end
                    end
                end
                c_ST_BODY: begin
                    if (w_xfer) begin
                        if (r_idx == 4'(FLITS_PER_PKT - 2)) begin
                            r_state <= c_ST_TAIL;
                            r_flit  <= FLIT_BITS'(mk_tail(c_PKT_ID_W'(r_pkt_id)));
                        end else begin
                            r_idx  <= r_idx + 4'd1;
                            r_flit <= FLIT_BITS'(mk_body(r_idx + 4'd1, c_TS_W'(r_pkt_ts)));
                        end
                    end
                end
                c_ST_TAIL: begin
                    if (w_xfer) begin
                        // The front entry pops now; if another waits behind it, start it with no bubble.
                        if (w_count > c_QCNT_W'(1)) begin
                            r_state  <= c_ST_HEAD;
                            r_dest   <= w_next[c_ENTRY_W-1 -: ADDR_BITS];
                            r_pkt_id <= w_next[2*CNT_BITS-1:CNT_BITS];
                            r_pkt_ts <= w_next[CNT_BITS-1:0];
                            r_flit   <= FLIT_BITS'(mk_head(c_DEST_W'(w_next[c_ENTRY_W-1 -: ADDR_BITS]),
                                                           c_SRC_W'(NODE_ID),
                                                           c_PKT_ID_W'(w_next[2*CNT_BITS-1:CNT_BITS])));
                        end else begin
                            r_state <= c_ST_IDLE;
                            r_valid <= 1'b0;
                            r_flit  <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_traffic_source.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_traffic_source : directed self-checking bench, two configs    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_traffic_source;

    logic        clk = 1'b0;
    logic        reset;
    logic        send_a, ready_a, valid_a, busy_a;
    logic [31:0] rand_a, flit_a;
    logic [15:0] inj_a, drop_a;
    logic        send_b, ready_b, valid_b, busy_b;
    logic [31:0] rand_b, flit_b;
    logic [15:0] inj_b, drop_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ts0, ts2, ts7;
    int tsq [8];
    logic [31:0] exp_seq [8];

    always #5 clk = ~clk;

    traffic_source #(
        .NODE_ID(0), .NUM_NODES(9), .ADDR_BITS(4), .RATE_THRESH(256), .FLITS_PER_PKT(4),
        .QUEUE_DEPTH(4), .FLIT_BITS(32), .CNT_BITS(16)
    ) u_dut_a (
        .clk(clk), .reset(reset), .send(send_a), .rand_val(rand_a), .flit_out(flit_a),
        .flit_valid(valid_a), .flit_ready(ready_a), .pkts_injected(inj_a),
        .pkts_dropped(drop_a), .busy(busy_a)
    );

    traffic_source #(
        .NODE_ID(4), .NUM_NODES(9), .ADDR_BITS(4), .RATE_THRESH(26), .FLITS_PER_PKT(2),
        .QUEUE_DEPTH(4), .FLIT_BITS(32), .CNT_BITS(16)
    ) u_dut_b (
        .clk(clk), .reset(reset), .send(send_b), .rand_val(rand_b), .flit_out(flit_b),
        .flit_valid(valid_b), .flit_ready(ready_b), .pkts_injected(inj_b),
        .pkts_dropped(drop_b), .busy(busy_b)
    );

    function automatic logic [31:0] f_head(input int dest, input int src, input int id);
        return (32'h1 << 30) | (32'(dest) << 26) | (32'(src) << 22) | (32'(id) << 6);
    endfunction

    function automatic logic [31:0] f_body(input int idx, input int ts);
        return (32'(idx) << 16) | (32'(ts) & 32'h0000_FFFF);
    endfunction

    function automatic logic [31:0] f_tail(input int id);
        return (32'h2 << 30) | (32'(id) << 6);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        reset = 1'b1;
        send_a = 0; rand_a = '0; ready_a = 0;
        send_b = 0; rand_b = '0; ready_b = 0;
        do_reset();

        check("rst_valid", {31'd0, valid_a}, 32'd0);
        check("rst_flit", flit_a, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_injected", {16'd0, inj_a}, 32'd0);
        check("rst_dropped", {16'd0, drop_a}, 32'd0);
        check("rst_valid_b", {31'd0, valid_b}, 32'd0);

        // Threshold boundary and self-destination remap on node 4, two-flit packets
        ready_b = 1; send_b = 1; rand_b = 32'h0000_0D1A;
        tick();
        check("b_thresh_26_no_req", {31'd0, busy_b}, 32'd0);
        rand_b = 32'h0000_0D19;
        tick();
        send_b = 0;
        check("b_thresh_25_req", {31'd0, busy_b}, 32'd1);
        tick();
        check("b_latch_no_valid", {31'd0, valid_b}, 32'd0);
        tick();
        check("b_remap_head", flit_b, f_head(5, 4, 0));
        check("b_head_valid", {31'd0, valid_b}, 32'd1);
        tick();
        check("b_tail", flit_b, f_tail(0));
        tick();
        check("b_idle_valid", {31'd0, valid_b}, 32'd0);
        check("b_injected", {16'd0, inj_b}, 32'd1);
        send_b = 1; rand_b = 32'h0000_1400;
        tick();
        send_b = 0;
        tick();
        tick();
        check("b_head_dest2", flit_b, f_head(2, 4, 1));

        // Always-inject: two requests back to back, no bubble between packets
        ready_a = 1; send_a = 1; rand_a = 32'h0000_0500; ts0 = cyc;
        tick();
        check("t1_e1_valid", {31'd0, valid_a}, 32'd0);
        tick();
        send_a = 0;
        check("t1_e2_valid", {31'd0, valid_a}, 32'd0);
        check("t1_e2_busy", {31'd0, busy_a}, 32'd1);
        tick();
        check("t1_head0_value", flit_a, 32'h5400_0000);
        exp_seq[0] = f_head(5, 0, 0); exp_seq[1] = f_body(1, ts0);
        exp_seq[2] = f_body(2, ts0);  exp_seq[3] = f_tail(0);
        exp_seq[4] = f_head(5, 0, 1); exp_seq[5] = f_body(1, ts0 + 1);
        exp_seq[6] = f_body(2, ts0 + 1); exp_seq[7] = f_tail(1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t1_flit%0d", i), flit_a, exp_seq[i]);
            check($sformatf("t1_valid%0d", i), {31'd0, valid_a}, 32'd1);
            tick();
        end
        check("t1_end_valid", {31'd0, valid_a}, 32'd0);
        check("t1_injected", {16'd0, inj_a}, 32'd2);
        check("t1_busy", {31'd0, busy_a}, 32'd0);

        // Backpressure during a body flit
        send_a = 1; ts2 = cyc;
        tick();
        send_a = 0;
        tick();
        tick();
        check("t3_head", flit_a, f_head(5, 0, 2));
        tick();
        check("t3_body1", flit_a, f_body(1, ts2));
        ready_a = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("t3_hold_flit%0d", i), flit_a, f_body(1, ts2));
            check($sformatf("t3_hold_valid%0d", i), {31'd0, valid_a}, 32'd1);
        end
        ready_a = 1;
        tick();
        check("t3_body2", flit_a, f_body(2, ts2));
        tick();
        check("t3_tail", flit_a, f_tail(2));
        tick();
        check("t3_idle", {31'd0, valid_a}, 32'd0);
        check("t3_injected", {16'd0, inj_a}, 32'd3);

        // Overflow: seven requests into a four-deep queue while the link is stalled
        do_reset();
        ready_a = 0; send_a = 1; rand_a = 32'h0000_0500;
        for (int i = 0; i < 7; i++) begin
            tsq[i] = cyc;
            tick();
        end
        send_a = 0;
        check("t4_dropped", {16'd0, drop_a}, 32'd3);
        check("t4_busy", {31'd0, busy_a}, 32'd1);
        check("t4_stalled_head", flit_a, f_head(5, 0, 0));
        ready_a = 1;
        for (int p = 0; p < 4; p++) begin
            check($sformatf("t4_p%0d_head", p), flit_a, f_head(5, 0, p));
            tick();
            check($sformatf("t4_p%0d_body1", p), flit_a, f_body(1, tsq[p]));
            tick();
            check($sformatf("t4_p%0d_body2", p), flit_a, f_body(2, tsq[p]));
            tick();
            check($sformatf("t4_p%0d_tail", p), flit_a, f_tail(p));
            tick();
        end
        check("t4_end_valid", {31'd0, valid_a}, 32'd0);
        check("t4_injected", {16'd0, inj_a}, 32'd4);
        check("t4_dropped_end", {16'd0, drop_a}, 32'd3);
        check("t4_busy_end", {31'd0, busy_a}, 32'd0);

        // Cool-down: three queued, send low, rand still below threshold
        ready_a = 0; send_a = 1;
        for (int i = 0; i < 3; i++) begin
            tsq[i] = cyc;
            tick();
        end
        send_a = 0;
        tick();
        tick();
        check("t5_dropped", {16'd0, drop_a}, 32'd3);
        check("t5_head", flit_a, f_head(5, 0, 4));
        ready_a = 1;
        for (int p = 0; p < 3; p++) begin
            check($sformatf("t5_p%0d_head", p), flit_a, f_head(5, 0, 4 + p));
            tick();
            check($sformatf("t5_p%0d_body1", p), flit_a, f_body(1, tsq[p]));
            tick();
            check($sformatf("t5_p%0d_body2", p), flit_a, f_body(2, tsq[p]));
            tick();
            check($sformatf("t5_p%0d_tail", p), flit_a, f_tail(4 + p));
            tick();
        end
        check("t5_busy_fall", {31'd0, busy_a}, 32'd0);
        check("t5_injected", {16'd0, inj_a}, 32'd7);
        tick();
        tick();
        tick();
        check("t5_no_new_req", {31'd0, busy_a}, 32'd0);
        check("t5_dropped_end", {16'd0, drop_a}, 32'd3);

        // Reset after the head transfer abandons the packet
        ready_a = 1; send_a = 1; ts7 = cyc;
        tick();
        send_a = 0;
        tick();
        tick();
        check("t6_head", flit_a, f_head(5, 0, 7));
        tick();
        check("t6_body1", flit_a, f_body(1, ts7));
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_valid", {31'd0, valid_a}, 32'd0);
        check("t6_async_flit", flit_a, 32'd0);
        check("t6_injected", {16'd0, inj_a}, 32'd0);
        check("t6_dropped", {16'd0, drop_a}, 32'd0);
        check("t6_busy", {31'd0, busy_a}, 32'd0);
        do_reset();
        send_a = 1;
        tick();
        send_a = 0;
        tick();
        tick();
        check("t6_head_after", flit_a, f_head(5, 0, 0));
        check("t6_valid_after", {31'd0, valid_a}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/traffic_source.md
Name: traffic_source

Overview:
- Per-node packet injector for the 3x3 NoC bench. It sits between the bench stimulus (`send` from the generator, 32-bit `rand` from the random-number block) and the local injection port of a router.
- It makes Bernoulli injection decisions and picks a random destination.
- Requests are queued in a small FIFO, then serialised into head/body/tail flits over a valid/ready link.
- Injected and dropped packets are counted for end-of-run statistics.

Parameters:
- NODE_ID, 0, this node's address (0..NUM_NODES-1)
- NUM_NODES, 9, number of nodes in the mesh
- ADDR_BITS, 4, width of src/dest fields
- RATE_THRESH, 26, injection threshold on rand[7:0]; probability = RATE_THRESH/256
- FLITS_PER_PKT, 4, flits per packet; range 2..15
- QUEUE_DEPTH, 4, pending-request FIFO depth; power of 2
- FLIT_BITS, 32, flit width
- CNT_BITS, 16, width of timestamp, packet-id and statistics counters

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- send  in  1  injection enable; 0 = cool-down, no new requests
- rand  in  32  fresh random word, sampled every cycle
- flit_out  out  FLIT_BITS  flit to router local port
- flit_valid  out  1  flit_out holds a valid flit
- flit_ready  in  1  router accepts flit this cycle
- pkts_injected  out  CNT_BITS  tail flits transferred
- pkts_dropped  out  CNT_BITS  requests lost to a full queue
- busy  out  1  queue non-empty or packet in flight

Behaviour:
- Reset is asynchronous: all counters 0, queue empty, FSM IDLE, flit_valid 0, flit_out 0, busy 0.
- Reset mid-packet abandons the packet. No tail is sent and counters are not incremented.
- A free-running timestamp counter `ts` increments every cycle and wraps.
- **Request:** at each rising edge with send=1 and rand[7:0] < RATE_THRESH, a request is generated.
  - dest = rand[15:8] mod NUM_NODES.
  - If dest == NODE_ID, dest = (NODE_ID+1) mod NUM_NODES.
  - Entry pushed = {dest, pkt_id, ts}; pkt_id then increments and wraps.
- **Push rule:** the push succeeds only if the queue is not full at that edge. There is no bypass: when the queue is full and a pop happens in the same cycle, the request is still dropped. A dropped request increments pkts_dropped and does not consume a pkt_id.
- **Serialiser FSM:**
  - States: IDLE, HEAD, BODY, TAIL.
  - IDLE -> HEAD when the queue is non-empty. The front entry is latched and flit_valid rises on the following cycle, so minimum request-to-head latency is 2 edges.
  - HEAD -> BODY, or HEAD -> TAIL when FLITS_PER_PKT == 2, on transfer.
  - BODY stays in BODY for FLITS_PER_PKT-2 transfers, then moves to TAIL.
  - TAIL -> IDLE on transfer, or TAIL -> HEAD directly if the queue still holds an entry. Back-to-back packets therefore have no bubble.
  - The queue pops on tail transfer.
- **Flit format:** [31:30] type, where 01 = head, 00 = body, 10 = tail.
  - Head: [29:26] dest, [25:22] src = NODE_ID, [21:6] pkt_id, rest 0.
  - Body: [19:16] body index from 1, [15:0] timestamp captured at request.
  - Tail: [21:6] pkt_id, rest 0.
- **Handshake:** a transfer happens when flit_valid && flit_ready at a rising edge. While valid && !ready, flit_out is held stable and valid is not dropped. flit_valid never depends combinationally on flit_ready.
- pkts_injected increments on tail transfer. Both statistics counters wrap.
- When send falls, requests stop immediately. The queued packets still drain completely; this is required for the cool-down period.
- busy = queue non-empty OR state != IDLE.

Decomposition:
- Package noc_pkg holds:
  - flit type codes and field offsets/widths (TYPE_HI/LO, DEST, SRC, PKT_ID, BODY_IDX, TS)
  - NUM_NODES and ADDR_BITS defaults
- Sub-module sync_fifo is a parameterised width/depth FIFO with push/pop/full/empty and no bypass. It is used for the request queue and is reusable by the sink.
- The FSM and counters stay in traffic_source.

Test Plan:
1. Always-inject check. Setup: RATE_THRESH=256, send=1, rand[15:8]=5, NODE_ID=0, flit_ready=1. Required:
   - Head 0x5400_0000 (dest 5, pkt_id 0) appears 2 edges after the first request edge.
   - 4 consecutive flits, then the next head with pkt_id 1 and no bubble.
2. Self-destination remap. Setup: NODE_ID=4, rand[15:8]=13 (13 mod 9 = 4). Required: head dest field = 5.
3. Backpressure. Setup: flit_ready=0 for 10 cycles during a body flit. Required:
   - flit_out constant and flit_valid=1 throughout.
   - The body index resumes correctly afterwards.
4. Overflow. Setup: flit_ready=0, inject 7 requests with QUEUE_DEPTH=4. Required:
   - pkts_dropped=3.
   - After release, exactly 4 packets with pkt_ids 0..3 are delivered and pkts_injected=4.
5. Cool-down. Setup: queue holds 3 entries, send drops to 0. Required:
   - No new requests are taken.
   - All 3 packets drain, busy then falls to 0.
6. Reset mid-packet. Setup: assert reset after the head transfer. Required:
   - flit_valid=0 immediately (asynchronously).
   - Counters 0; after release the first head carries pkt_id 0.
